// File: rtl/boxcar_pkg.sv
// Shared definitions for the boxcar decimator: default widths, the state
// encoding and the window-length clamp used when latching Shift.
package boxcar_pkg;

    localparam int MAX_SHIFT      = 8;
    localparam int DATA_W_DEFAULT = 16;
    localparam int ACC_W          = DATA_W_DEFAULT + MAX_SHIFT;
    localparam int SHIFT_W        = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Requested log2 window lengths above the supported maximum saturate to it
    function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] shift,
                                                      input int max_shift);
        if (int'(shift) > max_shift) begin
            return SHIFT_W'(max_shift);
        end
        return shift;
    endfunction

endpackage

// File: rtl/boxcar_decimator.sv
// Boxcar decimator: averages non-overlapping windows of 2^Shift valid samples
// and emits one registered result per window with a one-cycle OutValid strobe.
// Optional feature macro BOXCAR_ROUND_EN: round half up instead of truncating
// toward negative infinity.
module boxcar_decimator #(
    parameter int DATA_W    = 16,
    parameter int MAX_SHIFT = boxcar_pkg::MAX_SHIFT
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic signed [DATA_W-1:0] InData,
    input  logic                     InValid,
    input  logic                     Enable,
    input  logic                     Clear,
    input  logic [3:0]               Shift,
    output logic signed [DATA_W-1:0] OutData,
    output logic                     OutValid,
    output logic                     Busy
);

    import boxcar_pkg::*;

    // Accumulator holds up to 2^MAX_SHIFT full-scale samples without overflow
    localparam int ACC_WIDTH = DATA_W + MAX_SHIFT;
    localparam int CNT_W     = MAX_SHIFT + 1;

    state_t                        state;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic [CNT_W-1:0]              count;
    logic [SHIFT_W-1:0]            shift_q;
    logic [SHIFT_W-1:0]            shift_clamped;

    logic signed [ACC_WIDTH-1:0]   sample_ext;
    logic signed [ACC_WIDTH-1:0]   sum_next;
    logic signed [ACC_WIDTH-1:0]   round_bias;
    logic signed [ACC_WIDTH-1:0]   sum_biased;
    logic signed [ACC_WIDTH-1:0]   sum_shifted;
    logic signed [DATA_W-1:0]      avg;
    logic [CNT_W-1:0]              window_len;
    logic [CNT_W-1:0]              last_count;
    logic                          last_sample;

    assign shift_clamped = clamp_shift(Shift, MAX_SHIFT);
    assign sample_ext    = {{MAX_SHIFT{InData[DATA_W-1]}}, InData};
    assign sum_next      = acc + sample_ext;

`ifdef BOXCAR_ROUND_EN
    // Half an LSB of the result; the right shift makes this zero when shift_q is 0
    assign round_bias = (ACC_WIDTH'(1) << shift_q) >> 1;
`else
    assign round_bias = '0;
`endif

    // The average of in-range samples is itself in range, so dropping the
    // upper accumulator bits after the arithmetic shift never loses value
    assign sum_biased  = sum_next + round_bias;
    assign sum_shifted = sum_biased >>> shift_q;
    assign avg         = DATA_W'(sum_shifted);

    assign window_len  = CNT_W'(1) << shift_q;
    assign last_count  = window_len - CNT_W'(1);
    assign last_sample = (count == last_count);

    assign Busy = (state == ACCUM) && (count != '0);

    // Run/stop state machine with window accumulation, dump and abort handling
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            acc      <= '0;
            count    <= '0;
            shift_q  <= '0;
            OutData  <= '0;
            OutValid <= 1'b0;
        end else begin
            OutValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (Enable) begin
                        state   <= ACCUM;
                        shift_q <= shift_clamped;
                        acc     <= '0;
                        count   <= '0;
                    end
                end
                ACCUM: begin
                    if (!Enable) begin
                        state <= IDLE;
                        acc   <= '0;
                        count <= '0;
                    end else if (Clear) begin
                        acc   <= '0;
                        count <= '0;
                    end else if (InValid) begin
                        if (last_sample) begin
                            OutData  <= avg;
                            OutValid <= 1'b1;
                            acc      <= '0;
                            count    <= '0;
                            shift_q  <= shift_clamped;
                        end else begin
                            acc   <= sum_next;
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    acc   <= '0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boxcar_decimator.sv
// Self-checking bench for boxcar_decimator: directed window scenarios plus
// randomized traffic, checked by a scoreboard fed from a sample-list model.
module tb_boxcar_decimator;

    localparam int DATA_W    = 16;
    localparam int MAX_SHIFT = 8;

    logic                     Clk = 1'b0;
    logic                     Reset;
    logic signed [DATA_W-1:0] InData;
    logic                     InValid;
    logic                     Enable;
    logic                     Clear;
    logic [3:0]               Shift;
    logic signed [DATA_W-1:0] OutData;
    logic                     OutValid;
    logic                     Busy;

    int checks = 0;
    int errors = 0;

    int expQ[$];
    int window[$];
    bit mActive = 1'b0;
    int mShift  = 0;
    int lastOut = 0;
    bit mBusy   = 1'b0;

    boxcar_decimator #(.DATA_W(DATA_W), .MAX_SHIFT(MAX_SHIFT)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .InData  (InData),
        .InValid (InValid),
        .Enable  (Enable),
        .Clear   (Clear),
        .Shift   (Shift),
        .OutData (OutData),
        .OutValid(OutValid),
        .Busy    (Busy)
    );

    // Free-running 100 MHz clock
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int clampShift(input logic [3:0] sh);
        return (int'(sh) > MAX_SHIFT) ? MAX_SHIFT : int'(sh);
    endfunction

    // Mean of the collected window, floor or round-half-up
    function automatic int windowAverage(input int n);
        longint s = 0;
        foreach (window[i]) s += window[i];
`ifdef BOXCAR_ROUND_EN
        if (n > 0) s += longint'(1) << (n - 1);
`endif
        return int'(s >>> n);
    endfunction

    // Drive one cycle of inputs and advance the model for the edge that consumes them
    task automatic applyStimulus(input int d, input bit v, input bit en, input bit clr);
        InData  = DATA_W'(d);
        InValid = v;
        Enable  = en;
        Clear   = clr;
        if (!mActive) begin
            if (en) begin
                mActive = 1'b1;
                mShift  = clampShift(Shift);
                window.delete();
            end
        end else if (!en) begin
            mActive = 1'b0;
            window.delete();
        end else if (clr) begin
            window.delete();
        end else if (v) begin
            window.push_back(d);
            if (window.size() == (1 << mShift)) begin
                lastOut = windowAverage(mShift);
                expQ.push_back(lastOut);
                window.delete();
                mShift = clampShift(Shift);
            end
        end
        mBusy = mActive && (window.size() != 0);
        @(negedge Clk);
    endtask

    // Scoreboard monitor: every cycle, strobe/data/busy must match the model
    initial begin
        bit expStrobe;
        int e;
        forever begin
            @(posedge Clk);
            #1;
            expStrobe = (expQ.size() != 0);
            checkOutput("strobe", int'(OutValid), int'(expStrobe));
            if (expStrobe) begin
                e = expQ.pop_front();
                if (OutValid) checkOutput("average", int'(OutData), e);
            end else begin
                checkOutput("hold", int'(OutData), lastOut);
            end
            checkOutput("busy", int'(Busy), int'(mBusy));
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        logic signed [DATA_W-1:0] r;
        logic [3:0] shiftChoices [8];
        bit en;
        bit clr;
        bit v;

        shiftChoices = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd15};

        Reset   = 1'b1;
        InData  = '0;
        InValid = 1'b0;
        Enable  = 1'b0;
        Clear   = 1'b0;
        Shift   = 4'd0;
        #2 Reset = 1'b0;
        #1;
        checkOutput("reset_data", int'(OutData), 0);
        checkOutput("reset_valid", int'(OutValid), 0);
        checkOutput("reset_busy", int'(Busy), 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);

        $display("[TB] window of four, Shift=2");
        Shift = 4'd2;
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        applyStimulus(100, 1'b1, 1'b1, 1'b0);
        applyStimulus(200, 1'b1, 1'b1, 1'b0);
        applyStimulus(300, 1'b1, 1'b1, 1'b0);
        applyStimulus(400, 1'b1, 1'b1, 1'b0);
        checkOutput("avg4_data", int'(OutData), 250);
        checkOutput("avg4_strobe", int'(OutValid), 1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0);

        $display("[TB] negative pair, Shift=1");
        Shift = 4'd1;
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        applyStimulus(-3, 1'b1, 1'b1, 1'b0);
        applyStimulus(-2, 1'b1, 1'b1, 1'b0);
`ifdef BOXCAR_ROUND_EN
        checkOutput("neg_pair", int'(OutData), -2);
`else
        checkOutput("neg_pair", int'(OutData), -3);
`endif
        applyStimulus(0, 1'b0, 1'b0, 1'b0);

        $display("[TB] full-scale windows, Shift=8");
        Shift = 4'd8;
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 256; i++) applyStimulus(32767, 1'b1, 1'b1, 1'b0);
        checkOutput("fullscale_pos", int'(OutData), 32767);
        for (int i = 0; i < 256; i++) applyStimulus(-32768, 1'b1, 1'b1, 1'b0);
        checkOutput("fullscale_neg", int'(OutData), -32768);
        applyStimulus(0, 1'b0, 1'b0, 1'b0);

        $display("[TB] clear mid-window, Shift=2");
        Shift = 4'd2;
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        applyStimulus(11, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        applyStimulus(22, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        applyStimulus(33, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(10, 1'b1, 1'b1, 1'b0);
            if (i < 3) applyStimulus(0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("after_clear", int'(OutData), 10);
        applyStimulus(1, 1'b1, 1'b1, 1'b0);
        applyStimulus(2, 1'b1, 1'b1, 1'b0);
        applyStimulus(3, 1'b1, 1'b1, 1'b0);
        applyStimulus(4, 1'b1, 1'b1, 1'b1);
        checkOutput("clear_priority_valid", int'(OutValid), 0);
        checkOutput("clear_priority_data", int'(OutData), 10);
        applyStimulus(0, 1'b0, 1'b0, 1'b0);

        $display("[TB] pass-through, Shift=0");
        Shift = 4'd0;
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        applyStimulus(5, 1'b1, 1'b1, 1'b0);
        checkOutput("pass_5", int'(OutData), 5);
        checkOutput("pass_5_valid", int'(OutValid), 1);
        applyStimulus(-7, 1'b1, 1'b1, 1'b0);
        checkOutput("pass_m7", int'(OutData), -7);
        checkOutput("pass_m7_valid", int'(OutValid), 1);
        applyStimulus(9, 1'b1, 1'b1, 1'b0);
        checkOutput("pass_9", int'(OutData), 9);
        checkOutput("pass_9_valid", int'(OutValid), 1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0);

        $display("[TB] asynchronous reset mid-window");
        Shift = 4'd2;
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        applyStimulus(50, 1'b1, 1'b1, 1'b0);
        applyStimulus(60, 1'b1, 1'b1, 1'b0);
        #2 Reset = 1'b0;
        window.delete();
        mActive = 1'b0;
        mBusy   = 1'b0;
        lastOut = 0;
        #1;
        checkOutput("async_rst_data", int'(OutData), 0);
        checkOutput("async_rst_valid", int'(OutValid), 0);
        checkOutput("async_rst_busy", int'(Busy), 0);
        InValid = 1'b0;
        Enable  = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        applyStimulus(4, 1'b1, 1'b1, 1'b0);
        applyStimulus(8, 1'b1, 1'b1, 1'b0);
        applyStimulus(12, 1'b1, 1'b1, 1'b0);
        applyStimulus(16, 1'b1, 1'b1, 1'b0);
        checkOutput("post_reset_avg", int'(OutData), 10);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 49) == 0) Shift = shiftChoices[$urandom_range(0, 7)];
            r   = DATA_W'($urandom);
            en  = !(mActive && ($urandom_range(0, 299) == 0));
            clr = ($urandom_range(0, 149) == 0);
            v   = ($urandom_range(0, 3) != 0);
            applyStimulus(int'(r), v, en, clr);
        end

        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge Clk);
        checkOutput("scoreboard_drain", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/boxcar_decimator.md
BOXCAR_DECIMATOR -- requirements
Module: boxcar_decimator

Interface
REQ-001 SHALL have parameter DATA_W, default 16, input and output sample width (signed).
REQ-002 SHALL have parameter MAX_SHIFT, default 8, maximum log2 of window length.
REQ-003 SHALL have port Clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port InData  input  DATA_W signed  upstream sum/difference sample.
REQ-006 SHALL have port InValid  input  1  InData qualifier, one sample per high cycle.
REQ-007 SHALL have port Enable  input  1  run/stop.
REQ-008 SHALL have port Clear  input  1  synchronous abort of the current window.
REQ-009 SHALL have port Shift  input  4  log2 window length N; values above MAX_SHIFT clamp to MAX_SHIFT.
REQ-010 SHALL have port OutData  output  DATA_W signed  window average, registered.
REQ-011 SHALL have port OutValid  output  1  one-cycle strobe marking a new OutData.
REQ-012 SHALL have port Busy  output  1  high while a window is partially filled.

Function
REQ-013 SHALL use two states: IDLE (Enable=0) and ACCUM (Enable=1); IDLE->ACCUM when Enable=1, ACCUM->IDLE when Enable=0.
REQ-014 SHALL hold accumulator width DATA_W+MAX_SHIFT, sign-extending each InData so that no overflow is possible.
REQ-015 SHALL latch the clamped Shift into shift_q on entry to ACCUM and after each dump; a Shift change mid-window takes effect only from the next window.
REQ-016 SHALL, in ACCUM with InValid=1, add InData to the accumulator and increment the sample counter; InValid=0 cycles leave state unchanged.
REQ-017 SHALL, on the valid sample that brings the count to 2^shift_q, register OutData = (acc + InData) >>> shift_q (arithmetic) and pulse OutValid for exactly one cycle, one cycle after that sample.
REQ-018 SHALL clear the accumulator and counter in the same cycle as the dump, so a valid sample in the following cycle starts the new window without a gap.
REQ-019 SHALL, with shift_q=0, pass each valid sample to OutData with one-cycle latency.
REQ-020 SHALL, on Clear=1 or Enable falling mid-window, discard the partial window (accumulator and counter to 0, no OutValid); Clear has priority over a coincident final sample.
REQ-021 SHALL hold OutData at its last value between strobes, with OutValid=0.
REQ-022 SHALL drive Busy=1 iff the state is ACCUM and the counter is nonzero.

Reset
REQ-023 SHALL, while Reset=0, force state IDLE, accumulator 0, counter 0, shift_q 0, OutData 0, OutValid 0, Busy 0, independent of Clk.
REQ-024 SHALL, on reset assertion mid-window, drop the partial window with no OutValid produced.

Configuration
REQ-025 SHALL, when BOXCAR_ROUND_EN is defined, add 2^(shift_q-1) before the shift for shift_q>0 (round half up); otherwise SHALL truncate toward negative infinity.
REQ-026 SHALL produce, in either mode, a result that fits in DATA_W with no saturation logic, because the average of in-range samples stays in range.

Structure
REQ-027 SHALL place MAX_SHIFT, ACC_W (=DATA_W+MAX_SHIFT), the state enum and the Shift clamp function in a shared package boxcar_pkg.
REQ-028 SHALL be a single module with no sub-module.

Verification
REQ-029 SHALL cover: Shift=2, valid samples 100,200,300,400 -> OutData=250, OutValid high 1 cycle after the 4th sample.
REQ-030 SHALL cover: Shift=1, samples -3,-2 -> OutData=-3 truncating, -2 with BOXCAR_ROUND_EN.
REQ-031 SHALL cover: Shift=8, 256 samples of 32767 then 256 of -32768 -> 32767 then -32768, no overflow.
REQ-032 SHALL cover: Shift=2, InValid toggling 1/0, Clear pulsed after 3 samples -> no strobe; the next 4 samples of 10 -> OutData=10.
REQ-033 SHALL cover: Shift=0, back-to-back samples 5,-7,9 -> OutData 5,-7,9 on consecutive cycles with OutValid held high.
REQ-034 SHALL cover: Reset asserted asynchronously after 2 of 4 samples -> all outputs 0 immediately; after release with Enable=1 the next full window averages correctly.
